// File: rtl/bank_host_if.sv
// Host-side front end for a memory bank: accepts one request at a time, issues
// single-cycle w_en/r_en pulses and tracks the bank's precharge/write/sense sequence.
module bank_host_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              w_en,
  output logic              r_en,
  output logic [ADDR_W-1:0] bank_addr,
  output logic [DATA_W-1:0] bank_wdata,
  input  logic [DATA_W-1:0] sa_out
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WBUSY  = 3'd2,
    SENSE1 = 3'd3,
    SENSE2 = 3'd4,
    PRECH  = 3'd5
  } state_t;

  state_t state_r;
  state_t state_nxt_s;
  logic   op_we_r;
  logic   hs_s;

  // A pending response blocks acceptance so read data is never overwritten.
  assign req_ready = (state_r == IDLE) && !resp_valid;
  assign hs_s      = req_valid && req_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; every path returns through PRECH before IDLE.
  always_comb begin
    state_nxt_s = IDLE;
    case (state_r)
      IDLE:    state_nxt_s = hs_s ? ISSUE : IDLE;
      ISSUE:   state_nxt_s = op_we_r ? WBUSY : SENSE1;
      WBUSY:   state_nxt_s = PRECH;
      SENSE1:  state_nxt_s = SENSE2;
      SENSE2:  state_nxt_s = PRECH;
      PRECH:   state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Request capture, enable pulses and read-response holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_en       <= 1'b0;
      r_en       <= 1'b0;
      op_we_r    <= 1'b0;
      bank_addr  <= {ADDR_W{1'b0}};
      bank_wdata <= {DATA_W{1'b0}};
      resp_valid <= 1'b0;
      resp_rdata <= {DATA_W{1'b0}};
    end else begin
      // Enables are only ever set on the accepting edge, so ISSUE sees exactly one pulse.
      w_en <= hs_s && req_we;
      r_en <= hs_s && !req_we;
      if (hs_s) begin
        op_we_r    <= req_we;
        bank_addr  <= req_addr;
        bank_wdata <= req_wdata;
      end else begin
        op_we_r    <= op_we_r;
        bank_addr  <= bank_addr;
        bank_wdata <= bank_wdata;
      end
      if (state_r == SENSE2) begin
        resp_valid <= 1'b1;
        resp_rdata <= sa_out;
      end else if (resp_valid && resp_ready) begin
        resp_valid <= 1'b0;
        resp_rdata <= resp_rdata;
      end else begin
        resp_valid <= resp_valid;
        resp_rdata <= resp_rdata;
      end
    end
  end

endmodule
